// File: rtl/cute_key_sequencer_if.sv
// Key-provider interface for cute_key_sequencer: the serial load handshake from the
// key store, the clear strobe, and the time-varying key bus to the locked core.
interface cute_key_sequencer_if #(
    parameter int unsigned KEY_W    = 5,
    parameter int unsigned NUM_KEYS = 2
);
    localparam int unsigned PH_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    logic             load_valid;
    logic             load_data;
    logic             load_ready;
    logic             clear;
    logic [KEY_W-1:0] key_out;
    logic             key_active;
    logic [PH_W-1:0]  phase_idx;
    logic             load_err;

    modport master (
        output load_valid, load_data, clear,
        input  load_ready, key_out, key_active, phase_idx, load_err
    );

    modport slave (
        input  load_valid, load_data, clear,
        output load_ready, key_out, key_active, phase_idx, load_err
    );
endinterface

// File: rtl/cute_key_sequencer.sv
// Cute-Lock key sequencer: double-banked key schedule played out in step with the
// locked core's phase counter. Optional per-slot even parity: KEYSEQ_PARITY_EN.
module cute_key_sequencer #(
    parameter int unsigned KEY_W     = 5,
    parameter int unsigned NUM_KEYS  = 2,
    parameter int unsigned PHASE_LEN = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    cute_key_sequencer_if.slave   bus
);
    localparam int unsigned P    = NUM_KEYS * PHASE_LEN;
    localparam int unsigned N    = NUM_KEYS * KEY_W;
    localparam int unsigned MC_W = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned PH_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
`ifdef KEYSEQ_PARITY_EN
    localparam int unsigned SLOT_BITS = KEY_W + 1;
`else
    localparam int unsigned SLOT_BITS = KEY_W;
`endif
    localparam int unsigned POS_W = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;

    typedef enum logic [1:0] {EMPTY, SHIFT, PENDING, ACTIVE} state_t;

    state_t           state, state_d;
    logic [MC_W-1:0]  mc;
    logic [PH_W-1:0]  phase;
    logic [POS_W-1:0] bit_pos;
    logic [PH_W-1:0]  slot_cnt;
    logic [N-1:0]     shadow_bank, active_bank;
    logic             key_active_q;
    logic             load_ready;
    logic             accept, slot_end, last_bit, is_par, stream_bad;
    logic             commit, drop;

    assign load_ready = (state != PENDING);
    assign accept     = bus.load_valid && load_ready;
    assign slot_end   = (bit_pos == POS_W'(SLOT_BITS - 1));
    assign last_bit   = accept && slot_end && (slot_cnt == PH_W'(NUM_KEYS - 1));

`ifdef KEYSEQ_PARITY_EN
    logic par_acc, par_err, load_err_q, slot_err;

    assign is_par     = (bit_pos == POS_W'(KEY_W));
    assign slot_err   = is_par && (par_acc ^ bus.load_data);
    assign stream_bad = par_err || slot_err;
    assign bus.load_err = load_err_q;
`else
    assign is_par     = 1'b0;
    assign stream_bad = 1'b0;
    assign bus.load_err = 1'b0;
`endif

    // Free-running mirror of the locked core's counter; clear deliberately leaves it alone.
    always_ff @(negedge clk or posedge rst) begin
        if (rst)
            mc <= '0;
        else
            mc <= (mc == MC_W'(P - 1)) ? '0 : mc + 1'b1;
    end

    assign phase = PH_W'(mc / MC_W'(PHASE_LEN));

    always_ff @(negedge clk or posedge rst) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        commit  = 1'b0;
        drop    = 1'b0;
        case (state)
            EMPTY, SHIFT, ACTIVE: begin
                if (accept) begin
                    if (last_bit && stream_bad) begin
                        drop    = 1'b1;
                        state_d = key_active_q ? ACTIVE : EMPTY;
                    end else if (last_bit) begin
                        state_d = PENDING;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            PENDING: begin
                // Commit only at the period boundary so no period mixes old and new keys.
                if (mc == MC_W'(P - 1)) begin
                    commit  = 1'b1;
                    state_d = ACTIVE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (bus.clear) begin
            state_d = EMPTY;
            commit  = 1'b0;
            drop    = 1'b0;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            shadow_bank  <= '0;
            active_bank  <= '0;
            key_active_q <= 1'b0;
            bit_pos      <= '0;
            slot_cnt     <= '0;
        end else if (bus.clear) begin
            shadow_bank  <= '0;
            active_bank  <= '0;
            key_active_q <= 1'b0;
            bit_pos      <= '0;
            slot_cnt     <= '0;
        end else begin
            if (commit) begin
                active_bank  <= shadow_bank;
                key_active_q <= 1'b1;
            end
            if (accept) begin
                // Right shift lands the first streamed bit at slot 0, bit 0.
                if (!is_par)
                    shadow_bank <= {bus.load_data, shadow_bank[N-1:1]};
                if (slot_end) begin
                    bit_pos  <= '0;
                    slot_cnt <= last_bit ? '0 : slot_cnt + 1'b1;
                end else begin
                    bit_pos <= bit_pos + 1'b1;
                end
            end
            if (drop)
                shadow_bank <= '0;
        end
    end

`ifdef KEYSEQ_PARITY_EN
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            par_acc    <= 1'b0;
            par_err    <= 1'b0;
            load_err_q <= 1'b0;
        end else if (bus.clear) begin
            par_acc    <= 1'b0;
            par_err    <= 1'b0;
            load_err_q <= 1'b0;
        end else if (accept) begin
            par_acc <= is_par ? 1'b0 : (par_acc ^ bus.load_data);
            if (last_bit)
                par_err <= 1'b0;
            else if (slot_err)
                par_err <= 1'b1;
            if (drop)
                load_err_q <= 1'b1;
        end
    end
`endif

    assign bus.load_ready = load_ready;
    assign bus.key_active = key_active_q;
    assign bus.phase_idx  = phase;
    assign bus.key_out    = key_active_q ? active_bank[int'(phase) * KEY_W +: KEY_W] : '0;

endmodule

// File: tb/tb_cute_key_sequencer.sv
// Directed bench for cute_key_sequencer (KEY_W=5, NUM_KEYS=2, PHASE_LEN=2, P=4);
// also covers the KEYSEQ_PARITY_EN build.
module tb_cute_key_sequencer;
`ifdef KEYSEQ_PARITY_EN
    localparam int L = 12;
`else
    localparam int L = 10;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [1:0] tmc;
    int unsigned nvec = 0;
    int unsigned nerr = 0;

    cute_key_sequencer_if #(.KEY_W(5), .NUM_KEYS(2)) bus ();

    cute_key_sequencer #(.KEY_W(5), .NUM_KEYS(2), .PHASE_LEN(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference phase counter: falling edge, period 4, reset with the DUT.
    always @(negedge clk or posedge rst) begin
        if (rst) tmc <= 2'd0;
        else     tmc <= tmc + 2'd1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic b);
        bus.load_valid = 1'b1;
        bus.load_data  = b;
        cyc();
        bus.load_valid = 1'b0;
        bus.load_data  = 1'b0;
    endtask

    task automatic send_slot(input logic [4:0] w);
        for (int i = 0; i < 5; i++) send(w[i]);
`ifdef KEYSEQ_PARITY_EN
        send(^w);
`endif
    endtask

    task automatic align(input logic [1:0] t);
        for (int k = 0; k < 4 && tmc != t; k++) cyc();
    endtask

    // mc value at which to drive the first bit so the last bit is driven at mc==target
    function automatic logic [1:0] start_for(input int target);
        return 2'((target - ((L - 1) % 4) + 8) % 4);
    endfunction

    logic [1:0] exp_ph [8];

    initial begin
        exp_ph = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1};
        rst = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_data  = 1'b0;
        bus.clear      = 1'b0;
        cyc(); cyc();
        rst = 1'b0;

        // 1: reset values, idle phase sequence
        chk("rst_key_out", 32'(bus.key_out), 32'h0);
        chk("rst_key_active", 32'(bus.key_active), 32'h0);
        chk("rst_load_ready", 32'(bus.load_ready), 32'h1);
        chk("rst_load_err", 32'(bus.load_err), 32'h0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_phase%0d", i), 32'(bus.phase_idx), 32'(exp_ph[i]));
            chk($sformatf("t1_key%0d", i), 32'(bus.key_out), 32'h0);
            chk($sformatf("t1_act%0d", i), 32'(bus.key_active), 32'h0);
            cyc();
        end

        // 2: load 00111 / 01000, last bit driven at mc=1
        align(start_for(1));
        send_slot(5'b00111);
        send_slot(5'b01000);
        chk("t2_ready_pending", 32'(bus.load_ready), 32'h0);
        chk("t2_act_mc2", 32'(bus.key_active), 32'h0);
        cyc();
        chk("t2_act_mc3", 32'(bus.key_active), 32'h0);
        cyc();
        chk("t2_act_mc0", 32'(bus.key_active), 32'h1);
        chk("t2_key_mc0", 32'(bus.key_out), 32'h07);
        chk("t2_ready_active", 32'(bus.load_ready), 32'h1);
        cyc();
        chk("t2_key_mc1", 32'(bus.key_out), 32'h07);
        cyc();
        chk("t2_key_mc2", 32'(bus.key_out), 32'h08);
        chk("t2_phase_mc2", 32'(bus.phase_idx), 32'h1);
        cyc();
        chk("t2_key_mc3", 32'(bus.key_out), 32'h08);
        cyc();

        // 4: partial reload then clear
        send(1'b0); send(1'b0); send(1'b0);
        chk("t4_key_before_clear", 32'(bus.key_out), 32'h08);
        bus.clear = 1'b1;
        cyc();
        bus.clear = 1'b0;
        chk("t4_key_cleared", 32'(bus.key_out), 32'h0);
        chk("t4_act_cleared", 32'(bus.key_active), 32'h0);
        chk("t4_ready_cleared", 32'(bus.load_ready), 32'h1);
        chk("t4_phase0", 32'(bus.phase_idx), 32'h0);
        cyc(); cyc();
        chk("t4_phase_adv", 32'(bus.phase_idx), 32'h1);
        chk("t4_key_still0", 32'(bus.key_out), 32'h0);

        // 3: last bit accepted on the mc==3 edge, commit one period later
        align(start_for(3));
        send_slot(5'b10101);
        send_slot(5'b00011);
        chk("t3_act_edge0", 32'(bus.key_active), 32'h0);
        chk("t3_ready_pending", 32'(bus.load_ready), 32'h0);
        cyc(); cyc(); cyc();
        chk("t3_act_edge3", 32'(bus.key_active), 32'h0);
        cyc();
        chk("t3_act_edge4", 32'(bus.key_active), 32'h1);
        chk("t3_key_slot0", 32'(bus.key_out), 32'h15);
        cyc(); cyc();
        chk("t3_key_slot1", 32'(bus.key_out), 32'h03);

        // 5: rst mid-stream, then fresh full stream
        for (int i = 0; i < 6; i++) send(1'b1);
        rst = 1'b1;
        #1;
        chk("t5_rst_act", 32'(bus.key_active), 32'h0);
        chk("t5_rst_key", 32'(bus.key_out), 32'h0);
        chk("t5_rst_ready", 32'(bus.load_ready), 32'h1);
        cyc();
        rst = 1'b0;
        send_slot(5'b01010);
        send_slot(5'b10001);
        for (int k = 0; k < 12 && !bus.key_active; k++) cyc();
        chk("t5_act", 32'(bus.key_active), 32'h1);
        chk("t5_phase", 32'(bus.phase_idx), 32'h0);
        chk("t5_key_slot0", 32'(bus.key_out), 32'h0A);
        cyc(); cyc();
        chk("t5_key_slot1", 32'(bus.key_out), 32'h11);

`ifdef KEYSEQ_PARITY_EN
        // 6: reload with slot1 parity flipped over an active schedule
        chk("t6_err_before", 32'(bus.load_err), 32'h0);
        send_slot(5'b11100);
        for (int i = 0; i < 5; i++) send(5'b00110 >> i);
        send(~(^5'b00110));
        chk("t6_err", 32'(bus.load_err), 32'h1);
        chk("t6_act", 32'(bus.key_active), 32'h1);
        chk("t6_ready", 32'(bus.load_ready), 32'h1);
        repeat (4) cyc();
        align(2'd0);
        chk("t6_old_slot0", 32'(bus.key_out), 32'h0A);
        cyc(); cyc();
        chk("t6_old_slot1", 32'(bus.key_out), 32'h11);
        chk("t6_err_sticky", 32'(bus.load_err), 32'h1);
        bus.clear = 1'b1;
        cyc();
        bus.clear = 1'b0;
        chk("t6_err_cleared", 32'(bus.load_err), 32'h0);
`else
        chk("load_err_tied", 32'(bus.load_err), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
